uart_word_rx: RTL and testbench

Serial front end of `bitcoinminer`. Takes the 8N1 UART stream that `uart_tx` drives onto `serial_in` and recovers each byte. Assembles 36 consecutive bytes into one 288-bit word and presents it with a one-cycle `word_valid` strobe to the header/target loader downstream. Malformed or stalled frames are discarded so the next word always starts aligned.

---
 rtl/bitcoin_pkg.sv | 7 +
 rtl/uart_byte_rx.sv | 97 +++++++++
 rtl/uart_word_rx.sv | 87 ++++++++
 tb/tb_uart_word_rx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bitcoin_pkg.sv
// rtl/bitcoin_pkg.sv - shared constants and types for the miner serial path
package bitcoin_pkg;
   localparam int WORD_BITS         = 288;
   localparam int UART_CLKS_PER_BIT = 10;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 byte receiver: synchronizer, bit timer and frame FSM
module uart_byte_rx
   import bitcoin_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_error,
   output logic       start_seen,
   output logic       line_idle
);
   localparam int TW = $clog2(CLKS_PER_BIT);

   logic            rx_meta, rx_s;
   rx_state_t       state, state_d;
   logic [TW-1:0]   timer, timer_d;
   logic [2:0]      bit_idx, bit_idx_d;
   logic [7:0]      shift, shift_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         state   <= IDLE;
         timer   <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         rx_meta <= serial_in;
         rx_s    <= rx_meta;
         state   <= state_d;
         timer   <= timer_d;
         bit_idx <= bit_idx_d;
         shift   <= shift_d;
      end
   end

   // All samples land mid-bit: the half-bit start delay aligns later full-bit reloads.
   always_comb begin
      state_d     = state;
      timer_d     = timer;
      bit_idx_d   = bit_idx;
      shift_d     = shift;
      byte_valid  = 1'b0;
      frame_error = 1'b0;
      start_seen  = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               start_seen = 1'b1;
               timer_d    = TW'(CLKS_PER_BIT / 2 - 1);
               state_d    = START;
            end
         end
         START: begin
            if (timer == '0) begin
               if (!rx_s) begin
                  state_d   = DATA;
                  bit_idx_d = 3'd0;
                  timer_d   = TW'(CLKS_PER_BIT - 1);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               timer_d = timer - TW'(1);
            end
         end
         DATA: begin
            if (timer == '0) begin
               shift_d = {rx_s, shift[7:1]};
               timer_d = TW'(CLKS_PER_BIT - 1);
               if (bit_idx == 3'd7) state_d = STOP;
               else                 bit_idx_d = bit_idx + 3'd1;
            end else begin
               timer_d = timer - TW'(1);
            end
         end
         STOP: begin
            if (timer == '0) begin
               if (rx_s) byte_valid  = 1'b1;
               else      frame_error = 1'b1;
               state_d = IDLE;
            end else begin
               timer_d = timer - TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign byte_data = shift;
   assign line_idle = (state == IDLE);
endmodule

// File: rtl/uart_word_rx.sv
// rtl/uart_word_rx.sv - assembles received UART bytes into fixed-size words
module uart_word_rx
   import bitcoin_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int WORD_BYTES   = WORD_BITS / 8,
   parameter int TIMEOUT_CLKS = 400
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    serial_in,
   output logic [8*WORD_BYTES-1:0] rx_word,
   output logic                    word_valid,
   output logic                    framing_error,
   output logic                    timeout,
   output logic                    busy
);
   localparam int W   = 8 * WORD_BYTES;
   localparam int CW  = $clog2(WORD_BYTES + 1);
   localparam int TCW = $clog2(TIMEOUT_CLKS + 1);

   logic [7:0]     byte_data;
   logic           byte_valid, frame_error, start_seen, line_idle;
   logic [W-1:0]   shreg, shreg_next;
   logic [CW-1:0]  byte_cnt;
   logic [TCW-1:0] idle_cnt;

   uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
      .clk         (clk),
      .rst         (rst),
      .serial_in   (serial_in),
      .byte_data   (byte_data),
      .byte_valid  (byte_valid),
      .frame_error (frame_error),
      .start_seen  (start_seen),
      .line_idle   (line_idle)
   );

   // First byte of a word ends up in the top byte, matching the transmitter order.
   assign shreg_next = {shreg[W-9:0], byte_data};

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg         <= '0;
         rx_word       <= '0;
         byte_cnt      <= '0;
         idle_cnt      <= '0;
         word_valid    <= 1'b0;
         framing_error <= 1'b0;
         timeout       <= 1'b0;
      end else begin
         word_valid    <= 1'b0;
         framing_error <= 1'b0;
         timeout       <= 1'b0;
         if (byte_valid) begin
            shreg    <= shreg_next;
            idle_cnt <= '0;
            if (byte_cnt == CW'(WORD_BYTES - 1)) begin
               rx_word    <= shreg_next;
               word_valid <= 1'b1;
               byte_cnt   <= '0;
            end else begin
               byte_cnt <= byte_cnt + CW'(1);
            end
         end else if (frame_error) begin
            byte_cnt      <= '0;
            idle_cnt      <= '0;
            framing_error <= 1'b1;
         end else if (start_seen) begin
            // A start bit in the expiry cycle beats the timeout.
            idle_cnt <= '0;
         end else if (line_idle && byte_cnt != '0) begin
            if (idle_cnt == TCW'(TIMEOUT_CLKS - 1)) begin
               byte_cnt <= '0;
               idle_cnt <= '0;
               timeout  <= 1'b1;
            end else begin
               idle_cnt <= idle_cnt + TCW'(1);
            end
         end else begin
            idle_cnt <= '0;
         end
      end
   end

   assign busy = !line_idle || (byte_cnt != '0);
endmodule

// File: tb/tb_uart_word_rx.sv
// tb/tb_uart_word_rx.sv - randomized self-checking bench for uart_word_rx
module tb_uart_word_rx;
   localparam int CPB = 10;
   localparam int NB  = 36;
   localparam int TO  = 400;
   localparam int W   = 8 * NB;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         serial_in = 1'b1;
   logic [W-1:0] rx_word;
   logic         word_valid, framing_error, timeout, busy;

   int total = 0;
   int bad   = 0;
   int cyc = 0, wv_cnt = 0, fe_cnt = 0, to_cnt = 0, excl_bad = 0, to_cyc = 0;
   int busy_at_wv_hi = 0;
   logic [W-1:0] got_q[$];
   logic [W-1:0] exp_word = '0;

   uart_word_rx dut (
      .clk           (clk),
      .rst           (rst),
      .serial_in     (serial_in),
      .rx_word       (rx_word),
      .word_valid    (word_valid),
      .framing_error (framing_error),
      .timeout       (timeout),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (word_valid) begin
            wv_cnt <= wv_cnt + 1;
            got_q.push_back(rx_word);
            if (busy) busy_at_wv_hi <= busy_at_wv_hi + 1;
         end
         if (framing_error) fe_cnt <= fe_cnt + 1;
         if (timeout) begin
            to_cnt <= to_cnt + 1;
            to_cyc <= cyc;
         end
         if (int'(word_valid) + int'(framing_error) + int'(timeout) > 1) excl_bad <= excl_bad + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      serial_in = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         serial_in = b[i];
         tick(CPB);
      end
      serial_in = stop;
      tick(CPB);
      serial_in = 1'b1;
   endtask

   task automatic send_word(input logic [W-1:0] w);
      for (int i = 0; i < NB; i++) send_byte(w[W-1-8*i -: 8], 1'b1);
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w;
      for (int i = 0; i < W / 32; i++) w[32*i +: 32] = $urandom;
      return w;
   endfunction

   task automatic expect_word(input string name, input logic [W-1:0] w);
      int n0;
      n0 = wv_cnt;
      got_q.delete();
      send_word(w);
      tick(30);
      total++;
      if (wv_cnt - n0 !== 1) begin
         bad++;
         $display("FAIL %s_count: got %0d strobes, expected 1", name, wv_cnt - n0);
      end
      total++;
      if (got_q.size() != 1 || got_q[0] !== w) begin
         bad++;
         $display("FAIL %s_word: got %h expected %h", name, rx_word, w);
      end
      exp_word = w;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      total++;
      if ({rx_word, word_valid, framing_error, timeout, busy} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got word=%h wv=%b fe=%b to=%b busy=%b, expected all 0",
                  rx_word, word_valid, framing_error, timeout, busy);
      end
      rst = 1'b0;
      tick(5);
   endtask

   task automatic test_single();
      int b0;
      b0 = busy_at_wv_hi;
      expect_word("single", 288'h01000000b7bd9f286a77d60ac34fad57c74dd681ffb340b1095200426d0577e600000000);
      total++;
      if (busy_at_wv_hi !== b0) begin
         bad++;
         $display("FAIL single_busy: busy high at word_valid %0d times, expected 0", busy_at_wv_hi - b0);
      end
      total++;
      if (rx_word !== exp_word) begin
         bad++;
         $display("FAIL single_hold: got %h expected %h", rx_word, exp_word);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] w1, w2;
      int n0;
      w1 = 288'h01000000b7bd9f286a77d60ac34fad57c74dd681ffb340b1095200426d0577e600000000;
      w2 = 288'h49df9f013a1c5e770badf00d123456789abcdef0deadbeefcafebabe0f1e2d3c106a7449;
      n0 = wv_cnt;
      got_q.delete();
      send_word(w1);
      send_word(w2);
      tick(30);
      total++;
      if (wv_cnt - n0 !== 2) begin
         bad++;
         $display("FAIL b2b_count: got %0d strobes, expected 2", wv_cnt - n0);
      end
      total++;
      if (got_q.size() != 2 || got_q[0] !== w1 || got_q[1] !== w2) begin
         bad++;
         $display("FAIL b2b_words: got %0d words, last rx_word %h expected %h", got_q.size(), rx_word, w2);
      end
      exp_word = w2;
   endtask

   task automatic test_glitch();
      int n0, f0, t0;
      n0 = wv_cnt; f0 = fe_cnt; t0 = to_cnt;
      serial_in = 1'b0;
      tick(3);
      serial_in = 1'b1;
      tick(20);
      total++;
      if (wv_cnt - n0 + fe_cnt - f0 + to_cnt - t0 !== 0) begin
         bad++;
         $display("FAIL glitch_strobes: got %0d strobes, expected 0", wv_cnt - n0 + fe_cnt - f0 + to_cnt - t0);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL glitch_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_framing();
      int n0, f0;
      n0 = wv_cnt; f0 = fe_cnt;
      for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
      send_byte(8'($urandom), 1'b0);
      tick(2 * CPB);
      total++;
      if (fe_cnt - f0 !== 1) begin
         bad++;
         $display("FAIL frame_strobe: got %0d framing strobes, expected 1", fe_cnt - f0);
      end
      total++;
      if (wv_cnt - n0 !== 0 || rx_word !== exp_word) begin
         bad++;
         $display("FAIL frame_word: got %h (%0d strobes) expected %h", rx_word, wv_cnt - n0, exp_word);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL frame_busy: got %b expected 0", busy);
      end
      expect_word("frame_after", rand_word());
   endtask

   task automatic test_timeout();
      int t0, n0, t_end;
      t0 = to_cnt; n0 = wv_cnt;
      for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b1);
      t_end = cyc;
      tick(500);
      total++;
      if (to_cnt - t0 !== 1) begin
         bad++;
         $display("FAIL timeout_strobe: got %0d timeout strobes, expected 1", to_cnt - t0);
      end
      total++;
      if (to_cyc - t_end < TO - 20 || to_cyc - t_end > TO + 20) begin
         bad++;
         $display("FAIL timeout_time: got %0d idle cycles, expected about %0d", to_cyc - t_end, TO);
      end
      total++;
      if (busy !== 1'b0 || wv_cnt !== n0 || rx_word !== exp_word) begin
         bad++;
         $display("FAIL timeout_state: got busy=%b word=%h expected busy=0 word=%h", busy, rx_word, exp_word);
      end
      expect_word("timeout_after", {96'hffff001d00000000ffff0000, 192'h0});
   endtask

   task automatic test_reset_mid_word();
      for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      total++;
      if ({rx_word, word_valid, framing_error, timeout, busy} !== '0) begin
         bad++;
         $display("FAIL midreset_outputs: got word=%h wv=%b fe=%b to=%b busy=%b, expected all 0",
                  rx_word, word_valid, framing_error, timeout, busy);
      end
      exp_word = '0;
      tick(5);
      expect_word("midreset_after", rand_word());
   endtask

   task automatic test_random();
      for (int k = 0; k < 3; k++) begin
         tick($urandom_range(0, 50));
         expect_word("random", rand_word());
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_framing();
      test_timeout();
      test_reset_mid_word();
      test_random();
      total++;
      if (excl_bad !== 0) begin
         bad++;
         $display("FAIL strobe_exclusive: got %0d overlapping cycles, expected 0", excl_bad);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
